// File: rtl/avmm_read_burst_splitter_if.sv
// avmm_read_burst_splitter_if: command, Avalon-MM read and response signals of the burst splitter
interface avmm_read_burst_splitter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512,
   parameter int LEN_W  = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_address;
   logic [LEN_W-1:0]  cmd_length;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic [4:0]        avm_burstcount;
   logic              avm_waitrequest;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_readdatavalid;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_last;
   logic              busy;
   logic              err_unexpected;

   // the splitter masters the Avalon read bus and serves commands/responses
   modport master (
      input  cmd_valid, cmd_address, cmd_length,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  rsp_ready,
      output cmd_ready, avm_address, avm_read, avm_burstcount,
      output rsp_valid, rsp_data, rsp_last, busy, err_unexpected
   );

   // environment view: command source, read slave and response consumer
   modport slave (
      output cmd_valid, cmd_address, cmd_length,
      output avm_waitrequest, avm_readdata, avm_readdatavalid,
      output rsp_ready,
      input  cmd_ready, avm_address, avm_read, avm_burstcount,
      input  rsp_valid, rsp_data, rsp_last, busy, err_unexpected
   );
endinterface

// File: rtl/avmm_read_burst_splitter.sv
// avmm_read_burst_splitter: splits line-based read commands into page-safe Avalon bursts and buffers the returned lines
module avmm_read_burst_splitter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 512,
   parameter int LEN_W      = 16,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int PAGE_LINES = 64
) (
   input logic                         clk_clk,
   input logic                         reset_reset,
   avmm_read_burst_splitter_if.master  bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int PG_W  = $clog2(PAGE_LINES);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining, to_return;
   logic [CNT_W-1:0]  in_flight, fifo_count;
   logic [PTR_W-1:0]  wptr, rptr;
   logic [DATA_W:0]   mem [FIFO_DEPTH];
   logic [DATA_W:0]   head;
   logic [LEN_W-1:0]  lim_rem, lim_page, b_full;
   logic [4:0]        b;
   logic [CNT_W:0]    credit_sum;
   logic              credit_ok, read_req, cmd_acc, issue_acc, ret, stray, pop, last, err;

   // burst sizing and credit check, all from registered state so the request stays stable under waitrequest
   always_comb begin
      lim_rem    = remaining < LEN_W'(MAX_BURST) ? remaining : LEN_W'(MAX_BURST);
      lim_page   = LEN_W'(PAGE_LINES) - LEN_W'(addr[6 +: PG_W]);
      b_full     = lim_rem < lim_page ? lim_rem : lim_page;
      b          = 5'(b_full);
      credit_sum = (CNT_W+1)'(in_flight) + (CNT_W+1)'(fifo_count) + (CNT_W+1)'(b);
      credit_ok  = credit_sum <= (CNT_W+1)'(FIFO_DEPTH);
      read_req   = state == ISSUE && credit_ok;
      cmd_acc    = bus.cmd_valid && state == IDLE;
      issue_acc  = read_req && !bus.avm_waitrequest;
      ret        = bus.avm_readdatavalid && in_flight != '0;
      stray      = bus.avm_readdatavalid && in_flight == '0;
      pop        = fifo_count != '0 && bus.rsp_ready;
      last       = to_return == LEN_W'(1);
      head       = mem[rptr];
   end

   // state register
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) state <= IDLE;
      else state <= state_nxt;

   // next state: zero-length commands are absorbed in IDLE, WAIT ends with the final return
   always_comb
      state_nxt = (state == IDLE && cmd_acc && bus.cmd_length != '0) ? ISSUE :
                  (state == ISSUE && issue_acc && LEN_W'(b) == remaining) ? WAIT :
                  (state == WAIT && (to_return == '0 || (ret && last))) ? IDLE : state;

   // FSM-driven outputs; response data is masked while the FIFO is empty
   always_comb begin
      bus.cmd_ready      = state == IDLE;
      bus.busy           = state != IDLE;
      bus.avm_read       = read_req;
      bus.avm_address    = addr;
      bus.avm_burstcount = b;
      bus.rsp_valid      = fifo_count != '0;
      bus.rsp_data       = fifo_count != '0 ? head[DATA_W-1:0] : '0;
      bus.rsp_last       = fifo_count != '0 && head[DATA_W];
      bus.err_unexpected = err;
   end

   // command latch and burst walk through the buffer
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         addr      <= '0;
         remaining <= '0;
      end else if (cmd_acc && bus.cmd_length != '0) begin
         addr      <= bus.cmd_address & ~ADDR_W'(63);
         remaining <= bus.cmd_length;
      end else if (issue_acc) begin
         addr      <= addr + ADDR_W'({b, 6'b0});
         remaining <= remaining - LEN_W'(b);
      end

   // return accounting: lines outstanding on the bus and lines still owed to the consumer
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         to_return <= '0;
         in_flight <= '0;
         err       <= 1'b0;
      end else begin
         if (cmd_acc && bus.cmd_length != '0) to_return <= bus.cmd_length;
         else if (ret) to_return <= to_return - LEN_W'(1);
         in_flight <= in_flight + (issue_acc ? CNT_W'(b) : '0) - CNT_W'(ret);
         if (stray) err <= 1'b1;
      end

   // response FIFO pointers and occupancy
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
      end else begin
         if (ret) wptr <= wptr + PTR_W'(1);
         if (pop) rptr <= rptr + PTR_W'(1);
         fifo_count <= fifo_count + CNT_W'(ret) - CNT_W'(pop);
      end

   // response FIFO storage, tagged with the per-command last marker
   always_ff @(posedge clk_clk)
      if (ret) mem[wptr] <= {last, bus.avm_readdata};
endmodule

// File: tb/tb_avmm_read_burst_splitter.sv
// tb_avmm_read_burst_splitter: scoreboard bench with a modelled read slave and directed commands
module tb_avmm_read_burst_splitter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   avmm_read_burst_splitter_if bus();
   avmm_read_burst_splitter dut (.clk_clk(clk), .reset_reset(rst), .bus(bus));

   int n_cmp = 0, n_bad = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0]  eb_addr[$];
   int           eb_n[$];
   logic [512:0] er[$];
   logic [63:0]  pend[$];
   logic [63:0]  line_a, cap_a;
   logic [4:0]   cap_b;
   logic [512:0] e_rsp;
   int stall_cnt = 0, stall_seen = 0, issued = 0, popped = 0, max_out = 0;
   int last_rdv_cyc = 0, t_fall = 0, i0 = 0, p0 = 0;
   bit stray_req = 0, prev_busy = 0, any_read, any_rv, any_busy, all_rdy;

   function automatic logic [511:0] line_data(logic [63:0] a);
      return {8{a ^ 64'hA5A5_5A5A_0000_0000}};
   endfunction

   task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_burst(logic [63:0] a, int n);
      eb_addr.push_back(a);
      eb_n.push_back(n);
   endtask

   task automatic push_lines(logic [63:0] a, int n);
      for (int i = 0; i < n; i++) begin
         logic l;
         l = (i == n - 1);
         er.push_back({l, line_data(a + 64'(i) * 64)});
      end
   endtask

   task automatic send_cmd(logic [63:0] a, logic [15:0] n);
      int k = 0;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_address = a;
      bus.cmd_length = n;
      while (!bus.cmd_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_accept", k < 100, 1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(int budget);
      int k = 0;
      while ((bus.busy || er.size() != 0 || eb_n.size() != 0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("done_in_time", k < budget, 1);
   endtask

   // read slave: stalls on request, returns one line per cycle starting the cycle after acceptance
   initial begin
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.avm_waitrequest = 1'b0;
            bus.avm_readdatavalid = 1'b0;
            pend.delete();
            stall_seen = 0;
         end else begin
            if (stray_req) begin
               bus.avm_readdatavalid = 1'b1;
               bus.avm_readdata = {16{32'hDEADBEEF}};
               stray_req = 0;
            end else if (pend.size() > 0) begin
               line_a = pend.pop_front();
               bus.avm_readdatavalid = 1'b1;
               bus.avm_readdata = line_data(line_a);
               last_rdv_cyc = cyc;
            end else bus.avm_readdatavalid = 1'b0;
            if (bus.avm_read && stall_cnt > 0) begin
               bus.avm_waitrequest = 1'b1;
               stall_cnt--;
               if (stall_seen == 0) begin
                  cap_a = bus.avm_address;
                  cap_b = bus.avm_burstcount;
               end else begin
                  chk("stall_addr", bus.avm_address, cap_a);
                  chk("stall_bcnt", bus.avm_burstcount, cap_b);
               end
               stall_seen++;
            end else if (bus.avm_read) begin
               bus.avm_waitrequest = 1'b0;
               if (stall_seen > 0) chk("stall_cycles", stall_seen, 7);
               stall_seen = 0;
               if (eb_n.size() == 0) chk("burst_unexpected", bus.avm_burstcount, 0);
               else begin
                  chk("burst_addr", bus.avm_address, eb_addr.pop_front());
                  chk("burst_bcnt", bus.avm_burstcount, eb_n.pop_front());
               end
               for (int j = 0; j < int'(bus.avm_burstcount); j++) pend.push_back(bus.avm_address + 64'(j) * 64);
               issued += int'(bus.avm_burstcount);
               if (issued - popped > max_out) max_out = issued - popped;
            end else begin
               bus.avm_waitrequest = 1'b0;
               if (stall_seen > 0) chk("stall_read_held", bus.avm_read, 1);
               stall_seen = 0;
            end
         end
      end
   end

   // response monitor: pops the scoreboard on every accepted response line
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (prev_busy && !bus.busy) t_fall = cyc;
            prev_busy = bus.busy;
            if (bus.rsp_valid && bus.rsp_ready) begin
               popped++;
               if (er.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL rsp_unexpected: got line %0h, expected none", bus.rsp_data);
               end else begin
                  e_rsp = er.pop_front();
                  chk("rsp_data", bus.rsp_data, e_rsp[511:0]);
                  chk("rsp_last", bus.rsp_last, e_rsp[512]);
               end
            end
         end
      end
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_address = '0;
      bus.cmd_length = '0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_avm_read", bus.avm_read, 0);
      chk("rst_err", bus.err_unexpected, 0);
      rst = 1'b0;

      push_burst(64'h0, 16);
      push_burst(64'h400, 16);
      push_burst(64'h800, 8);
      push_lines(64'h0, 40);
      send_cmd(64'h0, 16'd40);
      wait_done(400);
      #2;
      chk("busy_fall_delay", t_fall - last_rdv_cyc, 1);

      push_burst(64'hF80, 2);
      push_burst(64'h1000, 3);
      push_lines(64'hF80, 5);
      send_cmd(64'hF9F, 16'd5);
      wait_done(200);

      bus.rsp_ready = 1'b0;
      max_out = 0;
      i0 = issued;
      p0 = popped;
      for (int i = 0; i < 12; i++) push_burst(64'h10000 + 64'(i) * 64'h400, 16);
      push_burst(64'h13000, 8);
      push_lines(64'h10000, 200);
      send_cmd(64'h10000, 16'd200);
      repeat (80) @(negedge clk);
      chk("credit_issued", issued - i0, 64);
      chk("credit_max", max_out, 64);
      chk("credit_rsp_hold", bus.rsp_valid, 1);
      chk("credit_busy", bus.busy, 1);
      bus.rsp_ready = 1'b1;
      wait_done(2000);
      chk("credit_max_end", max_out, 64);
      chk("credit_lines", popped - p0, 200);

      stall_cnt = 7;
      push_burst(64'h2000, 3);
      push_lines(64'h2000, 3);
      send_cmd(64'h2000, 16'd3);
      wait_done(200);

      send_cmd(64'h123, 16'd0);
      any_read = 0;
      any_rv = 0;
      any_busy = 0;
      all_rdy = 1;
      repeat (10) begin
         @(negedge clk);
         #1;
         any_read |= bus.avm_read;
         any_rv |= bus.rsp_valid;
         any_busy |= bus.busy;
         all_rdy &= bus.cmd_ready;
      end
      chk("len0_no_read", any_read, 0);
      chk("len0_no_rsp", any_rv, 0);
      chk("len0_no_busy", any_busy, 0);
      chk("len0_cmd_ready", all_rdy, 1);
      chk("err_before_stray", bus.err_unexpected, 0);
      #2 stray_req = 1;
      repeat (3) @(negedge clk);
      #1;
      chk("err_set", bus.err_unexpected, 1);
      chk("stray_no_rsp", bus.rsp_valid, 0);
      repeat (5) @(negedge clk);
      #1;
      chk("err_sticky", bus.err_unexpected, 1);

      @(negedge clk);
      #2 stall_cnt = 20;
      send_cmd(64'h0, 16'd64);
      repeat (3) @(negedge clk);
      chk("mid_issue_read", bus.avm_read, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_cmd_ready", bus.cmd_ready, 1);
      chk("arst_busy", bus.busy, 0);
      chk("arst_rsp_valid", bus.rsp_valid, 0);
      chk("arst_avm_read", bus.avm_read, 0);
      chk("arst_address", bus.avm_address, 0);
      chk("arst_err", bus.err_unexpected, 0);
      stall_cnt = 0;
      @(negedge clk);
      #2 rst = 1'b0;
      push_burst(64'h40, 1);
      push_lines(64'h40, 1);
      send_cmd(64'h40, 16'd1);
      wait_done(100);
      chk("queues_drained", er.size() + eb_n.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
